// File: rtl/ipv4_tx_arbiter_if.sv
// Bundle of client-side and IPv4-layer-side signals around the TX arbiter.
// The master modport is the arbiter's view; the slave modport is the view of
// the clients and the IPv4 layer.
interface ipv4_tx_arbiter_if #(
    parameter int unsigned N = 4
);
    logic [N-1:0]   req_w;
    logic [8*N-1:0] req_code;
    logic [N-1:0]   req_acpt;
    logic [N-1:0]   cli_ack;
    logic [N-1:0]   grant;
    logic [8*N-1:0] cli_data;
    logic [N-1:0]   cli_dven;
    logic [N-1:0]   cli_error;
    logic           dn_request;
    logic [7:0]     dn_requestcode;
    logic           dn_ack;
    logic [7:0]     dn_data;
    logic           dn_dven;
    logic           dn_error;
    logic           busy;
    logic [15:0]    tocnt;

    modport master (
        input  req_w, req_code, cli_data, cli_dven, cli_error, dn_ack,
        output req_acpt, cli_ack, grant, dn_request, dn_requestcode,
        output dn_data, dn_dven, dn_error, busy, tocnt
    );

    modport slave (
        output req_w, req_code, cli_data, cli_dven, cli_error, dn_ack,
        input  req_acpt, cli_ack, grant, dn_request, dn_requestcode,
        input  dn_data, dn_dven, dn_error, busy, tocnt
    );
endinterface

// File: rtl/ipv4_tx_arbiter.sv
// Round-robin arbiter sharing one IPv4 TX link between N protocol clients.
// Latches request pulses, runs the request/ack handshake for the winner and
// forwards the winner's byte stream with one cycle of latency.
module ipv4_tx_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned GAP     = 2
) (
    input logic               clk,
    input logic               reset,
    ipv4_tx_arbiter_if.master bus
);
    localparam int unsigned LW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        StIdle, StArb, StReq, StWait, StData, StAbort, StGap
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [LW-1:0] gidx_q, gidx_d;
    logic [LW-1:0] last_q, last_d;
    logic [7:0]    code_q, code_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   tocnt_q;
    logic [N-1:0]  req_acpt_q, cli_ack_q;
    logic [7:0]    dn_data_q;
    logic          dn_dven_q, dn_error_q;

    logic          win_found;
    logic [LW-1:0] win_idx;
    logic [LW-1:0] scan_idx;
    logic          fwd;

    // Round-robin pick: first pending index after the previous winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            scan_idx = LW'((32'(last_q) + k) % N);
            if (!win_found && pending_q[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Next-state logic; cnt counts cycles spent in the current state.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | bus.req_w;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        last_d    = last_q;
        code_d    = code_q;
        cnt_d     = cnt_q + 16'd1;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if ((|pending_q) || (|bus.req_w)) state_d = StArb;
            end
            StArb: begin
                cnt_d = '0;
                if (win_found) begin
                    grant_d   = N'(1) << win_idx;
                    gidx_d    = win_idx;
                    last_d    = win_idx;
                    code_d    = bus.req_code[{win_idx, 3'b000} +: 8];
                    // A new pulse on the winner in this cycle survives the clear.
                    pending_d = (pending_q & ~(N'(1) << win_idx)) | bus.req_w;
                    state_d   = StReq;
                end else begin
                    state_d = StIdle;
                end
            end
            StReq: begin
                if (bus.dn_ack) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    state_d = StAbort;
                    cnt_d   = '0;
                end
            end
            StWait: begin
                if (bus.cli_dven[gidx_q]) begin
                    state_d = StData;
                    cnt_d   = '0;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    state_d = StAbort;
                    cnt_d   = '0;
                end
            end
            StData: begin
                if (!bus.cli_dven[gidx_q]) begin
                    state_d = StGap;
                    cnt_d   = '0;
                    grant_d = '0;
                    code_d  = '0;
                end
            end
            StAbort: begin
                state_d = StGap;
                cnt_d   = '0;
                grant_d = '0;
                code_d  = '0;
            end
            StGap: begin
                if (cnt_q == 16'(GAP - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                grant_d = '0;
            end
        endcase
    end

    assign fwd = (state_q == StWait) || (state_q == StData);

    // State, arbitration bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            pending_q  <= '0;
            grant_q    <= '0;
            gidx_q     <= '0;
            last_q     <= LW'(N - 1);
            code_q     <= '0;
            cnt_q      <= '0;
            tocnt_q    <= '0;
            req_acpt_q <= '0;
            cli_ack_q  <= '0;
            dn_data_q  <= '0;
            dn_dven_q  <= 1'b0;
            dn_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            last_q     <= last_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
            req_acpt_q <= bus.req_w;
            cli_ack_q  <= (state_q == StReq && bus.dn_ack) ? grant_q : '0;
            if (state_q == StAbort && tocnt_q != 16'hFFFF) begin
                tocnt_q <= tocnt_q + 16'd1;
            end
            dn_data_q  <= fwd ? bus.cli_data[{gidx_q, 3'b000} +: 8] : 8'h00;
            dn_dven_q  <= fwd ? bus.cli_dven[gidx_q] : 1'b0;
            dn_error_q <= fwd ? bus.cli_error[gidx_q] : 1'b0;
        end
    end

    assign bus.req_acpt       = req_acpt_q;
    assign bus.cli_ack        = cli_ack_q;
    assign bus.grant          = grant_q;
    assign bus.dn_request     = (state_q == StReq);
    assign bus.dn_requestcode = code_q;
    assign bus.dn_data        = dn_data_q;
    assign bus.dn_dven        = dn_dven_q;
    assign bus.dn_error       = dn_error_q;
    assign bus.busy           = (state_q != StIdle);
    assign bus.tocnt          = tocnt_q;
endmodule

// File: tb/tb_ipv4_tx_arbiter.sv
// Directed bench for ipv4_tx_arbiter with N=4, TIMEOUT=16, GAP=2.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ipv4_tx_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   w;
    int   n;
    logic [3:0] ack_seen;

    ipv4_tx_arbiter_if #(.N(4)) bus ();

    ipv4_tx_arbiter #(
        .N(4),
        .TIMEOUT(16),
        .GAP(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for dn_request, checks the grant, acks after ack_dly cycles, then sends
    // nb bytes from client c. mid is pulsed on req_w with the first byte; noise makes
    // client 1 drive a competing stream that must be ignored.
    task automatic serve(input int c, input int nb, input logic [7:0] base,
                         input logic [3:0] mid, input bit noise, input int ack_dly,
                         output int waited);
        logic [3:0] g;
        g = 4'(1) << c;
        waited = 0;
        while (bus.dn_request !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("req_seen", 32'(bus.dn_request), 1);
        chk("grant", 32'(bus.grant), 32'(g));
        chk("code", 32'(bus.dn_requestcode), 32'(c + 1));
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            chk("req_hold", 32'(bus.dn_request), 1);
        end
        bus.dn_ack = 1'b1;
        @(negedge clk);
        bus.dn_ack = 1'b0;
        chk("cli_ack", 32'(bus.cli_ack), 32'(g));
        chk("req_drop", 32'(bus.dn_request), 0);
        for (int b = 0; b < nb; b++) begin
            bus.cli_dven[c] = 1'b1;
            bus.cli_data[8*c +: 8] = base + 8'(b);
            if (b == 0) bus.req_w = mid;
            if (noise) begin
                bus.cli_dven[1] = 1'b1;
                bus.cli_data[15:8] = 8'hEE;
                bus.cli_error[1] = 1'b1;
            end
            @(negedge clk);
            bus.req_w = '0;
            if (b == 0) chk("mid_acpt", 32'(bus.req_acpt), 32'(mid));
            chk("dn_data", 32'(bus.dn_data), 32'(base + 8'(b)));
            chk("dn_dven", 32'(bus.dn_dven), 1);
            chk("dn_error", 32'(bus.dn_error), 0);
        end
        bus.cli_dven[c] = 1'b0;
        @(negedge clk);
        chk("end_dven", 32'(bus.dn_dven), 0);
        chk("end_grant", 32'(bus.grant), 0);
        bus.cli_dven[1] = 1'b0;
        bus.cli_error[1] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_w = '0;
        bus.req_code = {8'h04, 8'h03, 8'h02, 8'h01};
        bus.cli_data = '0;
        bus.cli_dven = '0;
        bus.cli_error = '0;
        bus.dn_ack = 1'b0;

        // Reset state
        #2;
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_req", 32'(bus.dn_request), 0);
        chk("rst_tocnt", 32'(bus.tocnt), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Single client 0, ack three cycles after request, 8 bytes 0x45..0x4C
        @(negedge clk);
        bus.req_w = 4'b0001;
        @(negedge clk);
        bus.req_w = '0;
        chk("t1_acpt", 32'(bus.req_acpt), 32'h1);
        chk("t1_busy_arb", 32'(bus.busy), 1);
        chk("t1_req_arb", 32'(bus.dn_request), 0);
        serve(0, 8, 8'h45, 4'b0000, 1'b0, 3, w);
        chk("t1_wait", 32'(w), 1);
        @(negedge clk);
        chk("t1_gap_busy", 32'(bus.busy), 1);
        @(negedge clk);
        chk("t1_idle", 32'(bus.busy), 0);

        // dn_ack while idle is ignored
        bus.dn_ack = 1'b1;
        @(negedge clk);
        bus.dn_ack = 1'b0;
        chk("ack_idle_busy", 32'(bus.busy), 0);
        chk("ack_idle_cliack", 32'(bus.cli_ack), 0);

        // All four request at once after reset: served 0,1,2,3 with GAP spacing
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bus.req_w = 4'b1111;
        @(negedge clk);
        bus.req_w = '0;
        chk("t2_acpt", 32'(bus.req_acpt), 32'hF);
        serve(0, 2, 8'h20, 4'b0000, 1'b0, 0, w);
        serve(1, 2, 8'h30, 4'b0000, 1'b0, 0, w);
        chk("t2_gap1", 32'(w), 4);
        serve(2, 2, 8'h40, 4'b0000, 1'b0, 0, w);
        chk("t2_gap2", 32'(w), 4);
        serve(3, 2, 8'h50, 4'b0000, 1'b0, 0, w);
        chk("t2_gap3", 32'(w), 4);
        repeat (2) @(negedge clk);
        chk("t2_idle", 32'(bus.busy), 0);

        // Fairness: 0 re-requests during its frame alongside 2; 2 goes first,
        // then 0 with client 1 driving a competing stream
        bus.req_w = 4'b0001;
        @(negedge clk);
        bus.req_w = '0;
        serve(0, 3, 8'h10, 4'b0101, 1'b0, 0, w);
        serve(2, 2, 8'h60, 4'b0000, 1'b0, 0, w);
        serve(0, 3, 8'h70, 4'b0000, 1'b1, 0, w);
        repeat (2) @(negedge clk);
        chk("t3_idle", 32'(bus.busy), 0);

        // Ack never comes for client 1: abort after 16 REQ cycles, then client 3
        bus.req_w = 4'b0010;
        @(negedge clk);
        bus.req_w = 4'b1000;
        @(negedge clk);
        bus.req_w = '0;
        chk("t4_grant", 32'(bus.grant), 32'h2);
        n = 0;
        ack_seen = '0;
        while (bus.dn_request === 1'b1 && n < 100) begin
            ack_seen |= bus.cli_ack;
            @(negedge clk);
            n++;
        end
        chk("t4_req_cycles", 32'(n), 16);
        chk("t4_abort_busy", 32'(bus.busy), 1);
        chk("t4_no_ack", 32'(ack_seen | bus.cli_ack), 0);
        @(negedge clk);
        chk("t4_tocnt", 32'(bus.tocnt), 1);
        chk("t4_gap_grant", 32'(bus.grant), 0);
        serve(3, 2, 8'h80, 4'b0000, 1'b0, 0, w);
        chk("t4_next_wait", 32'(w), 4);
        repeat (2) @(negedge clk);
        chk("t4_idle", 32'(bus.busy), 0);

        // Reset mid-frame with clients 2 and 3 pending
        bus.req_w = 4'b0001;
        @(negedge clk);
        bus.req_w = '0;
        @(negedge clk);
        bus.dn_ack = 1'b1;
        @(negedge clk);
        bus.dn_ack = 1'b0;
        bus.cli_dven[0] = 1'b1;
        bus.cli_data[7:0] = 8'hA1;
        bus.req_w = 4'b1100;
        @(negedge clk);
        bus.req_w = '0;
        bus.cli_data[7:0] = 8'hA2;
        @(negedge clk);
        chk("t6_pre_dven", 32'(bus.dn_dven), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_dven", 32'(bus.dn_dven), 0);
        chk("t6_grant", 32'(bus.grant), 0);
        chk("t6_req", 32'(bus.dn_request), 0);
        chk("t6_tocnt", 32'(bus.tocnt), 0);
        @(negedge clk);
        reset = 1'b1;
        bus.cli_dven = '0;
        repeat (5) @(negedge clk);
        chk("t6_post_busy", 32'(bus.busy), 0);
        chk("t6_post_grant", 32'(bus.grant), 0);
        chk("t6_post_tocnt", 32'(bus.tocnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ipv4_tx_arbiter.md
# ipv4_tx_arbiter

Shares the single IPv4 transmit link between N protocol clients (ICMP, UDP, ...). Latches one-cycle request pulses per client, picks one round-robin, runs the request/requestcode/ack handshake toward the IPv4 layer on that client's behalf, then forwards that client's byte stream until its frame ends. Sits between the protocol blocks and the IPv4 TX path, replacing point-to-point request/ack wiring.

## Interface
Parameters:
- N, 4, number of clients (2..8)
- TIMEOUT, 1023, max cycles waited for dn_ack, and separately for the first client byte after ack
- GAP, 2, idle cycles enforced between frames (>=1)

Ports:
- clk  in  1  sole clock
- reset  in  1  **one clock; reset is asynchronous and active-low** (low = reset)
- req_w  in  N  one-cycle request pulse per client
- req_code  in  8*N  protocol code per client, slice i = [8i+7:8i]; sampled at grant
- req_acpt  out  N  one-cycle pulse, cycle after req_w[i]
- cli_ack  out  N  one-cycle pulse to granted client, cycle after dn_ack
- grant  out  N  one-hot owner, zero when idle
- cli_data  in  8*N  client TX bytes
- cli_dven  in  N  client byte valid
- cli_error  in  N  client error flag
- dn_request  out  1  level request to IPv4 layer
- dn_requestcode  out  8  code of current grant
- dn_ack  in  1  one-cycle ack from IPv4 layer
- dn_data  out  8  forwarded byte
- dn_dven  out  1  forwarded valid
- dn_error  out  1  forwarded error
- busy  out  1  high whenever state != IDLE
- tocnt  out  16  saturating count of timeouts

## Operation
- pending[N]: set by req_w[i]; cleared when i is granted in ARB. req_w[i] in same cycle as its clear leaves it set (new request wins).
- Round-robin pointer last (reset N-1): ARB picks the first pending index scanning last+1, last+2, ... mod N; last <= winner.
- States:
  - IDLE: any pending -> ARB.
  - ARB (1 cycle): register grant, dn_requestcode <= req_code[winner], clear pending[winner] -> REQ.
  - REQ: dn_request=1. dn_ack -> WAITDATA, dn_request drops next cycle. TIMEOUT cycles without ack -> ABORT.
  - WAITDATA: cli_dven[g] high -> DATA. TIMEOUT cycles without it -> ABORT.
  - DATA: forward client g. cli_dven[g] low -> GAP.
  - ABORT (1 cycle): tocnt++ (saturate at 16'hFFFF), request dropped, no retry -> GAP.
  - GAP: GAP cycles, grant=0 -> IDLE.
- Forwarding: dn_data/dn_dven/dn_error registered from cli_*[g] only in WAITDATA/DATA; zero otherwise. Non-granted clients' streams ignored.
- dn_ack outside REQ is ignored; cli_dven of non-granted clients ignored.
- Reset (any time, incl. mid-frame): all outputs 0, pending 0, last=N-1, tocnt 0, state IDLE; partial frame truncated with dn_dven low.

## Timing
- req_w[i] at cycle t: req_acpt[i] at t+1, pending visible t+1; from IDLE, ARB at t+1, dn_request high t+2.
- dn_ack at cycle a: cli_ack[g] and state WAITDATA at a+1; dn_request low at a+1.
- Datapath latency exactly 1 cycle: cli byte at c -> dn_data at c+1. First byte seen in WAITDATA is forwarded, not dropped.
- Frame end: cli_dven[g] low at e -> dn_dven low at e+1, GAP from e+1, next ARB no earlier than e+1+GAP.
- Timeout counters count cycles in state; ABORT on the TIMEOUT-th cycle without event; event on that same cycle wins.

## Test plan
- Single client 0: req_w[0] at t=10 -> req_acpt[0] t=11, dn_request t=12 with code 8'h01; dn_ack t=15 -> cli_ack[0] t=16; 8 bytes 0x45..0x4C -> identical on dn_data, 1-cycle delay, dn_dven low after last.
- Simultaneous req_w=4'b1111 after reset -> grants in order 0,1,2,3, each GAP cycles apart, codes match per client.
- Fairness: client 0 re-requests during its own frame while client 2 pending -> client 2 served before client 0's second frame.
- dn_ack never arrives, TIMEOUT=16 -> ABORT after 16 REQ cycles, tocnt=1, client not acked, next pending client granted.
- Non-granted client 1 drives dven=1 during client 0 frame -> dn_data only carries client 0 bytes.
- Reset asserted mid DATA -> dn_dven, grant, dn_request 0 immediately (async); after release, earlier pending requests gone, tocnt 0.
